// File: rtl/ej32_pkg.sv
// Shared definitions for the ej32 data stack.
// Holds the stack command encoding and the default geometry.
package ej32_pkg;

    typedef enum logic [1:0] {
        OP_NOP  = 2'b00,
        OP_PUSH = 2'b01,
        OP_POP  = 2'b10,
        OP_PICK = 2'b11
    } stack_ops;

    localparam int EJ32_DEPTH = 64;
    localparam int EJ32_DSZ   = 32;

endpackage

// File: rtl/ej32_stack_rf.sv
// Storage for the stack entries below top-of-stack.
// One synchronous write port and one asynchronous read port; there is no reset and no backpressure.
module ej32_stack_rf
    import ej32_pkg::*;
#(
    parameter int DEPTH = EJ32_DEPTH,
    parameter int DSZ   = EJ32_DSZ,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           i_we,
    input  logic [AW-1:0]  i_waddr,
    input  logic [DSZ-1:0] i_wdata,
    input  logic [AW-1:0]  i_raddr,
    output logic [DSZ-1:0] o_rdata
);

    logic [DSZ-1:0] r_mem [DEPTH-1];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/ej32_dstack.sv
// ej32 data stack: registered top-of-stack plus a register file holding the entries beneath it.
// Latency 1 cycle; never stalls: a new op is accepted every cycle and bad ops only raise sticky flags.
module ej32_dstack
    import ej32_pkg::*;
#(
    parameter int DEPTH = EJ32_DEPTH,
    parameter int DSZ   = EJ32_DSZ
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [1:0]               op,
    input  logic [DSZ-1:0]           vi,
    output logic [DSZ-1:0]           s,
    output logic [$clog2(DEPTH):0]   sp,
    output logic                     empty,
    output logic                     full,
    output logic                     ovf,
    output logic                     udf
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] SP_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] SP_ONE  = (AW+1)'(1);
    localparam logic [AW:0] SP_TWO  = (AW+1)'(2);

    logic [DSZ-1:0] r_tos;
    logic [AW:0]    r_sp;
    logic           r_ovf;
    logic           r_udf;

    stack_ops       w_op;
    logic [AW:0]    w_n;
    logic           w_empty;
    logic           w_full;
    logic [AW:0]    w_raddr_wide;
    logic [AW:0]    w_waddr_wide;
    logic [DSZ-1:0] w_rdata;
    logic           w_we;
    logic           w_do_push;
    logic [DSZ-1:0] w_push_val;
    logic [DSZ-1:0] w_tos_nxt;
    logic [AW:0]    w_sp_nxt;
    logic           w_ovf_nxt;
    logic           w_udf_nxt;

    assign w_op    = stack_ops'(op);
    assign w_n     = {1'b0, vi[AW-1:0]};
    assign w_empty = (r_sp == '0);
    assign w_full  = (r_sp == SP_FULL);

    // POP reads next-under (sp-2); PICK n reads sp-1-n. PICK 1 and POP share an address.
    assign w_raddr_wide = (w_op == OP_POP) ? (r_sp - SP_TWO) : (r_sp - SP_ONE - w_n);
    assign w_waddr_wide = r_sp - SP_ONE;

    ej32_stack_rf #(
        .DEPTH (DEPTH),
        .DSZ   (DSZ),
        .AW    (AW)
    ) u_rf (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr_wide[AW-1:0]),
        .i_wdata (r_tos),
        .i_raddr (w_raddr_wide[AW-1:0]),
        .o_rdata (w_rdata)
    );

    always_comb begin
        w_tos_nxt  = r_tos;
        w_sp_nxt   = r_sp;
        w_ovf_nxt  = r_ovf;
        w_udf_nxt  = r_udf;
        w_we       = 1'b0;
        w_do_push  = 1'b0;
        w_push_val = vi;
        case (w_op)
            OP_PUSH: begin
                if (w_full) w_ovf_nxt = 1'b1;
                else        w_do_push = 1'b1;
            end
            OP_POP: begin
                if (w_empty) begin
                    w_udf_nxt = 1'b1;
                end else if (r_sp == SP_ONE) begin
                    w_tos_nxt = '0;
                    w_sp_nxt  = '0;
                end else begin
                    w_tos_nxt = w_rdata;
                    w_sp_nxt  = r_sp - SP_ONE;
                end
            end
            OP_PICK: begin
                if (w_n >= r_sp) begin
                    w_udf_nxt = 1'b1;
                end else if (w_full) begin
                    w_ovf_nxt = 1'b1;
                end else begin
                    w_do_push  = 1'b1;
                    w_push_val = (w_n == '0) ? r_tos : w_rdata;
                end
            end
            default: ;
        endcase
        // An empty stack has no old TOS worth spilling into the array.
        if (w_do_push) begin
            w_we      = !w_empty;
            w_tos_nxt = w_push_val;
            w_sp_nxt  = r_sp + SP_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tos <= '0;
            r_sp  <= '0;
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            r_tos <= w_tos_nxt;
            r_sp  <= w_sp_nxt;
            r_ovf <= w_ovf_nxt;
            r_udf <= w_udf_nxt;
        end
    end

    assign s     = r_tos;
    assign sp    = r_sp;
    assign empty = w_empty;
    assign full  = w_full;
    assign ovf   = r_ovf;
    assign udf   = r_udf;

endmodule

// File: tb/tb_ej32_dstack.sv
// Bench for ej32_dstack: stimulus pushes expected observations into a queue, a monitor compares each cycle.
// The reference is a plain queue of values with sticky error bits.
module tb_ej32_dstack;

    localparam int DEPTH = 64;
    localparam int DSZ   = 32;
    localparam int AW    = 6;

    localparam logic [1:0] NOP  = 2'b00;
    localparam logic [1:0] PUSH = 2'b01;
    localparam logic [1:0] POP  = 2'b10;
    localparam logic [1:0] PICK = 2'b11;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [1:0]     op  = 2'b00;
    logic [DSZ-1:0] vi  = '0;
    logic [DSZ-1:0] s;
    logic [AW:0]    sp;
    logic           empty, full, ovf, udf;

    always #5 clk = ~clk;

    ej32_dstack #(.DEPTH(DEPTH), .DSZ(DSZ)) dut (
        .clk   (clk),
        .rst   (rst),
        .op    (op),
        .vi    (vi),
        .s     (s),
        .sp    (sp),
        .empty (empty),
        .full  (full),
        .ovf   (ovf),
        .udf   (udf)
    );

    typedef struct packed {
        logic [DSZ-1:0] s;
        logic [AW:0]    sp;
        logic           empty;
        logic           full;
        logic           ovf;
        logic           udf;
    } obs_t;

    obs_t  exp_q[$];
    string name_q[$];
    int    tests = 0;
    int    fails = 0;

    logic [DSZ-1:0] model[$];
    logic           m_ovf = 1'b0;
    logic           m_udf = 1'b0;

    function automatic obs_t model_obs();
        obs_t o;
        o.s     = (model.size() > 0) ? model[model.size()-1] : '0;
        o.sp    = (AW+1)'(model.size());
        o.empty = (model.size() == 0);
        o.full  = (model.size() == DEPTH);
        o.ovf   = m_ovf;
        o.udf   = m_udf;
        return o;
    endfunction

    function automatic obs_t dut_obs();
        obs_t o;
        o.s     = s;
        o.sp    = sp;
        o.empty = empty;
        o.full  = full;
        o.ovf   = ovf;
        o.udf   = udf;
        return o;
    endfunction

    function automatic void model_step(input logic [1:0] o, input logic [DSZ-1:0] v);
        int n;
        int sz;
        n  = int'(v[AW-1:0]);
        sz = model.size();
        case (o)
            PUSH: if (sz == DEPTH) m_ovf = 1'b1; else model.push_back(v);
            POP:  if (sz == 0) m_udf = 1'b1; else void'(model.pop_back());
            PICK: begin
                if (n >= sz)         m_udf = 1'b1;
                else if (sz == DEPTH) m_ovf = 1'b1;
                else                 model.push_back(model[sz-1-n]);
            end
            default: ;
        endcase
    endfunction

    task automatic check(input string nm, input obs_t got, input obs_t req);
        tests++;
        if (got !== req) begin
            fails++;
            $display("FAIL %s: got s=%h sp=%0d empty=%b full=%b ovf=%b udf=%b, required s=%h sp=%0d empty=%b full=%b ovf=%b udf=%b",
                     nm, got.s, got.sp, got.empty, got.full, got.ovf, got.udf,
                     req.s, req.sp, req.empty, req.full, req.ovf, req.udf);
        end
    endtask

    task automatic do_op(input logic [1:0] o, input logic [DSZ-1:0] v, input string nm);
        @(negedge clk);
        op = o;
        vi = v;
        model_step(o, v);
        exp_q.push_back(model_obs());
        name_q.push_back(nm);
    endtask

    task automatic drain(input string nm);
        do_op(NOP, $urandom(), {nm, "_nop"});
        for (int k = 0; k < 6 && exp_q.size() > 0; k++) begin
            @(posedge clk);
            #2;
        end
        if (exp_q.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL %s_drain: %0d expectations still pending, required 0", nm, exp_q.size());
            exp_q.delete();
            name_q.delete();
        end
    endtask

    // Asserts rst mid-cycle, after the previous edge's result has been checked.
    task automatic apply_reset(input string nm);
        obs_t zero;
        zero       = '0;
        zero.empty = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check(nm, dut_obs(), zero);
        model.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
        @(negedge clk);
        op  = NOP;
        rst = 1'b0;
    endtask

    obs_t  mon_e;
    string mon_n;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                mon_n = name_q.pop_front();
                check(mon_n, dut_obs(), mon_e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DSZ-1:0] v;
        int r;
        int push_pct;
        #1 rst = 1'b1;
        #12;
        begin
            obs_t zero;
            zero       = '0;
            zero.empty = 1'b1;
            check("power_on_reset", dut_obs(), zero);
        end
        @(negedge clk);
        rst = 1'b0;

        // Basic push/pop.
        do_op(PUSH, 32'h11, "push_11");
        do_op(PUSH, 32'h22, "push_22");
        do_op(PUSH, 32'h33, "push_33");
        do_op(POP,  '0,     "pop_to_22");
        do_op(POP,  '0,     "pop_to_11");
        do_op(POP,  '0,     "pop_to_empty");
        drain("basic");

        // Fill, overflow, then unwind.
        for (int i = 1; i <= DEPTH; i++) do_op(PUSH, DSZ'(i), $sformatf("fill_%0d", i));
        do_op(PUSH, 32'hDEAD, "push_overflow");
        do_op(PICK, 32'h0,    "pick_at_full");
        for (int i = 0; i < DEPTH; i++) do_op(POP, '0, $sformatf("unwind_%0d", i));
        drain("fill");
        apply_reset("reset_after_fill");

        // PICK behaviour.
        do_op(PUSH, 32'hA, "push_A");
        do_op(PUSH, 32'hB, "push_B");
        do_op(PUSH, 32'hC, "push_C");
        do_op(PICK, 32'h0, "pick0_dup");
        do_op(PICK, 32'h3, "pick3");
        do_op(PICK, 32'h5, "pick5_bad");
        do_op(PICK, 32'hFFFF_FF41, "pick1_upper_bits_ignored");
        drain("pick");
        apply_reset("reset_after_pick");

        // Underflow on empty, sticky through a later push.
        do_op(POP,  '0,    "pop_empty");
        do_op(PUSH, 32'h5, "push_5_udf_sticky");
        drain("underflow");
        apply_reset("reset_after_underflow");

        // Asynchronous reset mid-sequence.
        do_op(PUSH, 32'h1, "push_1");
        do_op(PUSH, 32'h2, "push_2");
        apply_reset("async_reset_mid_seq");
        do_op(PUSH, 32'h7, "push_7_after_reset");
        drain("async");

        // Alternating push/pop every cycle.
        for (int i = 0; i < 1000; i++) begin
            if (i % 2 == 0) do_op(PUSH, $urandom(), "alt_push");
            else            do_op(POP,  $urandom(), "alt_pop");
        end
        drain("alternating");
        apply_reset("reset_before_random");

        // Mixed random ops with alternating bias so both full and empty are reached.
        for (int i = 0; i < 1200; i++) begin
            push_pct = ((i / 150) % 2 == 0) ? 75 : 20;
            r = $urandom_range(0, 99);
            v = $urandom();
            if (r < push_pct) begin
                do_op(PUSH, v, "rnd_push");
            end else if (r < push_pct + 15) begin
                v[AW-1:0] = AW'($urandom_range(0, model.size() + 2));
                do_op(PICK, v, "rnd_pick");
            end else if (r < 95) begin
                do_op(POP, v, "rnd_pop");
            end else begin
                do_op(NOP, v, "rnd_nop");
            end
        end
        drain("random");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ej32_dstack.md
EJ32_DSTACK -- requirements
Module: ej32_dstack

Interface
REQ-001 Parameter DEPTH, default 64, maximum number of stacked entries including top-of-stack; power of two, minimum 4.
REQ-002 Parameter DSZ, default 32, data width in bits.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 op  input  2  stack_ops command: NOP=00, PUSH=01, POP=10, PICK=11.
REQ-006 vi  input  DSZ  PUSH data; for PICK, vi[$clog2(DEPTH)-1:0] is pick index n, upper bits ignored.
REQ-007 s  output  DSZ  current top-of-stack, registered.
REQ-008 sp  output  $clog2(DEPTH)+1  current depth, 0..DEPTH.
REQ-009 empty  output  1  high when sp==0.
REQ-010 full  output  1  high when sp==DEPTH.
REQ-011 ovf  output  1  sticky overflow error.
REQ-012 udf  output  1  sticky underflow or bad-pick error.

Function
REQ-013 The block SHALL hold top-of-stack in a TOS register (drives s) and entries below it in a DEPTH-1 deep array addressed by sp-2 for the next-under element.
REQ-014 op SHALL be sampled on each rising clk; the result SHALL be visible on s/sp/flags in the following cycle (1-cycle latency), with a new op accepted every cycle.
REQ-015 NOP SHALL leave all state unchanged.
REQ-016 PUSH with sp<DEPTH: array[sp-1] <= TOS (skipped when sp==0), TOS <= vi, sp <= sp+1.
REQ-017 PUSH with sp==DEPTH: state unchanged, ovf <= 1.
REQ-018 POP with sp>1: TOS <= array[sp-2], sp <= sp-1.
REQ-019 POP with sp==1: TOS <= 0, sp <= 0.
REQ-020 POP with sp==0: state unchanged, s stays 0, udf <= 1.
REQ-021 PICK n with n<sp and sp<DEPTH: pushes a copy of element n (n=0 is TOS, i.e. DUP; n=1 is array[sp-2]; generally array[sp-1-n]), behaving as PUSH of that value.
REQ-022 PICK n with n>=sp: state unchanged, udf <= 1.
REQ-023 PICK with sp==DEPTH and n<sp: state unchanged, ovf <= 1.
REQ-024 empty and full SHALL be combinational decodes of registered sp, never both high.
REQ-025 ovf and udf SHALL remain set until rst; errored ops SHALL NOT corrupt stored data.
REQ-026 Array contents at and above depth sp are don't-care and SHALL never reach s.

Reset
REQ-027 Asserting rst at any time, including mid-sequence, SHALL immediately force s=0, sp=0, empty=1, full=0, ovf=0, udf=0.
REQ-028 Array contents SHALL NOT require reset.
REQ-029 First op SHALL be accepted on the first rising clk after rst deasserts.

Structure
REQ-030 The stack_ops typedef and default DEPTH/DSZ constants SHALL live in the shared package ej32_pkg.
REQ-031 Storage SHALL be a sub-module ej32_stack_rf: (DEPTH-1)xDSZ, one synchronous write port, one asynchronous read port serving POP (sp-2) and PICK (sp-1-n) under a mux.
REQ-032 A master driving ss_io (op, vi, s) SHALL connect to ej32_dstack without glue logic.

Verification
REQ-033 Reset then PUSH 0x11, 0x22, 0x33 -> s=0x33, sp=3; POP -> s=0x22, sp=2; POP, POP -> s=0, sp=0, empty=1, udf=0.
REQ-034 Fill DEPTH=64 with PUSH i (i=1..64) -> full=1, s=64; extra PUSH 0xDEAD -> s=64, sp=64, ovf=1; then 64 POPs return 64..1 in order.
REQ-035 Stack 0xA,0xB,0xC: PICK 0 -> s=0xC, sp=4; PICK 3 -> s=0xA, sp=5; PICK 5 -> unchanged, udf=1.
REQ-036 POP on empty after reset -> s=0, sp=0, udf=1; udf persists through subsequent PUSH 0x5 (s=0x5, sp=1).
REQ-037 PUSH 0x1,0x2, assert rst asynchronously between clock edges -> s=0, sp=0, ovf=udf=0 before next edge; PUSH 0x7 -> s=0x7, sp=1.
REQ-038 Back-to-back alternating PUSH/POP every cycle for 1000 random cycles -> s and sp match a reference queue model each cycle.
